// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
// Game score keeper. A new game loads START into the score. While the game
// runs, a divider produces a one-second tick that subtracts PENALTY from the
// score and advances the elapsed-second counter. Single-cycle bonus requests
// add to the score. The game ends on gameover or when the score reaches zero.
// The best final score is retained in high_score until reset.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   reset          : synchronous, active-high reset
//   start_i        : level, begins a new game from IDLE or OVER
//   pause_i        : level, high holds a running game in PAUSE
//   gameover_i     : level, ends the game from RUN or PAUSE
//   bonus_valid_i  : one-cycle request to add bonus_amt_i to the score
//   bonus_amt_i    : unsigned bonus value
//   score_o        : current score (registered)
//   high_score_o   : best final score since reset (registered)
//   elapsed_sec_o  : ticks elapsed in RUN during this game (registered)
//   state_o        : IDLE=0, RUN=1, PAUSE=2, OVER=3 (registered)
//   tick_out_o     : one-cycle pulse coincident with a tick's score update
//   new_high_o     : one-cycle pulse when high_score is updated
// -----------------------------------------------------------------------------
module score_keeper #(
    parameter int unsigned    TICK_DIV = 100000000,
    parameter int unsigned    W        = 16,
    parameter logic [W-1:0]   START    = '1,
    parameter int unsigned    PENALTY  = 65,
    parameter int unsigned    BONUS_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic               gameover_i,
    input  logic               bonus_valid_i,
    input  logic [BONUS_W-1:0] bonus_amt_i,
    output logic [W-1:0]       score_o,
    output logic [W-1:0]       high_score_o,
    output logic [W-1:0]       elapsed_sec_o,
    output logic [1:0]         state_o,
    output logic               tick_out_o,
    output logic               new_high_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int unsigned DIV_W = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 32'd1);
    localparam logic [W-1:0]     PEN_L    = W'(PENALTY);
    localparam logic [W-1:0]     MAX_L    = '1;
    // Score arithmetic is done two bits wider and signed so that both the
    // underflow below zero and the overflow above 2^W-1 are visible.
    localparam logic signed [W+1:0] MAX_EXT = {2'b00, MAX_L};

    state_t           state_q, state_d;
    logic [W-1:0]     score_q, score_d;
    logic [W-1:0]     high_q, high_d;
    logic [W-1:0]     elapsed_q, elapsed_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             new_high_q, new_high_d;

    logic                 load_s;
    logic                 do_tick_s;
    logic                 do_bonus_s;
    logic signed [W+1:0]  sum_s;

    // Next-state, datapath and pulse generation.
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        elapsed_d  = elapsed_q;
        div_d      = div_q;
        tick_d     = 1'b0;
        new_high_d = 1'b0;
        load_s     = 1'b0;
        do_tick_s  = 1'b0;
        do_bonus_s = 1'b0;
        sum_s      = {2'b00, score_q};

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A zero score ends the game on the edge after it was reached.
                if (gameover_i || (score_q == {W{1'b0}})) begin
                    state_d = ST_OVER;
                end else if (pause_i) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d    = ST_RUN;
                    do_bonus_s = bonus_valid_i;
                    if (div_q == DIV_LAST) begin
                        div_d     = {DIV_W{1'b0}};
                        do_tick_s = 1'b1;
                    end else begin
                        div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_PAUSE: begin
                if (gameover_i) begin
                    state_d = ST_OVER;
                end else if (!pause_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_OVER: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            score_d   = START;
            elapsed_d = {W{1'b0}};
            div_d     = {DIV_W{1'b0}};
        end else if (do_tick_s || do_bonus_s) begin
            sum_s = {2'b00, score_q}
                  - (do_tick_s  ? $signed({2'b00, PEN_L}) : $signed({(W+2){1'b0}}))
                  + (do_bonus_s ? $signed({{(W+2-BONUS_W){1'b0}}, bonus_amt_i})
                                : $signed({(W+2){1'b0}}));
            if (sum_s < $signed({(W+2){1'b0}})) begin
                score_d = {W{1'b0}};
            end else if (sum_s > MAX_EXT) begin
                score_d = MAX_L;
            end else begin
                score_d = sum_s[W-1:0];
            end
        end else begin
            score_d = score_q;
        end

        if (do_tick_s) begin
            tick_d = 1'b1;
            if (elapsed_q != MAX_L) begin
                elapsed_d = elapsed_q + {{(W-1){1'b0}}, 1'b1};
            end else begin
                elapsed_d = elapsed_q;
            end
        end else begin
            tick_d = 1'b0;
        end

        // Score holds on every edge that enters OVER, so score_q is the final score.
        if ((state_d == ST_OVER) && (state_q != ST_OVER) && (score_q > high_q)) begin
            high_d     = score_q;
            new_high_d = 1'b1;
        end else begin
            high_d     = high_q;
            new_high_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            score_q    <= {W{1'b0}};
            high_q     <= {W{1'b0}};
            elapsed_q  <= {W{1'b0}};
            div_q      <= {DIV_W{1'b0}};
            tick_q     <= 1'b0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            elapsed_q  <= elapsed_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            new_high_q <= new_high_d;
        end
    end

    assign score_o       = score_q;
    assign high_score_o  = high_q;
    assign elapsed_sec_o = elapsed_q;
    assign state_o       = state_q;
    assign tick_out_o    = tick_q;
    assign new_high_o    = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT 1: default START
    logic        r1, s1, p1, g1, bv1;
    logic [7:0]  ba1;
    logic [15:0] sc1, hs1, el1;
    logic [1:0]  st1;
    logic        tk1, nh1;

    // DUT 2: START=100
    logic        r2, s2, p2, g2, bv2;
    logic [7:0]  ba2;
    logic [15:0] sc2, hs2, el2;
    logic [1:0]  st2;
    logic        tk2, nh2;

    score_keeper #(.TICK_DIV(4), .W(16), .START(16'd65535), .PENALTY(65), .BONUS_W(8)) u_dut1 (
        .clk(clk), .reset(r1), .start_i(s1), .pause_i(p1), .gameover_i(g1),
        .bonus_valid_i(bv1), .bonus_amt_i(ba1), .score_o(sc1), .high_score_o(hs1),
        .elapsed_sec_o(el1), .state_o(st1), .tick_out_o(tk1), .new_high_o(nh1)
    );

    score_keeper #(.TICK_DIV(4), .W(16), .START(16'd100), .PENALTY(65), .BONUS_W(8)) u_dut2 (
        .clk(clk), .reset(r2), .start_i(s2), .pause_i(p2), .gameover_i(g2),
        .bonus_valid_i(bv2), .bonus_amt_i(ba2), .score_o(sc2), .high_score_o(hs2),
        .elapsed_sec_o(el2), .state_o(st2), .tick_out_o(tk2), .new_high_o(nh2)
    );

    typedef struct {
        logic        rst, st, pa, go, bv;
        logic [7:0]  ba;
        logic [1:0]  e_state;
        logic [15:0] e_score, e_el, e_hs;
        logic        e_tick, e_nh;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, st, pa, go, bv, input logic [7:0] ba,
                       input logic [1:0] es, input logic [15:0] esc, eel, ehs,
                       input logic et, enh);
        vec_t v;
        v.rst = rst; v.st = st; v.pa = pa; v.go = go; v.bv = bv; v.ba = ba;
        v.e_state = es; v.e_score = esc; v.e_el = eel; v.e_hs = ehs;
        v.e_tick = et; v.e_nh = enh;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step1(input logic rst, st, pa, go, bv, input logic [7:0] ba);
        r1 = rst; s1 = st; p1 = pa; g1 = go; bv1 = bv; ba1 = ba;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic rst, st, pa, go, bv, input logic [7:0] ba);
        r2 = rst; s2 = st; p2 = pa; g2 = go; bv2 = bv; ba2 = ba;
        @(posedge clk);
        #1;
    endtask

    initial begin
        r1 = 1'b1; s1 = 1'b0; p1 = 1'b0; g1 = 1'b0; bv1 = 1'b0; ba1 = 8'd0;
        r2 = 1'b1; s2 = 1'b0; p2 = 1'b0; g2 = 1'b0; bv2 = 1'b0; ba2 = 8'd0;

        // ---------------- vector table for DUT 1 ----------------
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        // bonus in IDLE ignored
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd50,  2'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   2'd1, 16'd65535, 16'd0, 16'd0, 1'b0, 1'b0);
        // 12 running cycles: ticks on the 4th, 8th and 12th; start in RUN ignored
        for (int k = 1; k <= 12; k++) begin
            add(1'b0, (k == 2), 1'b0, 1'b0, 1'b0, 8'd0, 2'd1,
                16'(65535 - 65 * (k / 4)), 16'(k / 4), 16'd0, (k % 4 == 0), 1'b0);
        end
        // divider to 2, then pause (bonus on the pause edge ignored)
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd1, 16'd65340, 16'd3, 16'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd1, 16'd65340, 16'd3, 16'd0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            add(1'b0, (k == 5), 1'b1, 1'b0, (k == 0), 8'd100, 2'd2,
                16'd65340, 16'd3, 16'd0, 1'b0, 1'b0);
        end
        // resume: divider held at 2, tick two edges later
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd1, 16'd65340, 16'd3, 16'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd1, 16'd65340, 16'd3, 16'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd1, 16'd65275, 16'd4, 16'd0, 1'b1, 1'b0);
        // bonus without tick, then tick+bonus clamped high, then bonus clamped
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd225, 2'd1, 16'd65500, 16'd4, 16'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd1, 16'd65500, 16'd4, 16'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd1, 16'd65500, 16'd4, 16'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd200, 2'd1, 16'd65535, 16'd5, 16'd0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd255, 2'd1, 16'd65535, 16'd5, 16'd0, 1'b0, 1'b0);
        // gameover: new high, pulse one cycle, bonus in OVER ignored
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   2'd3, 16'd65535, 16'd5, 16'd65535, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd3, 16'd65535, 16'd5, 16'd65535, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd9,   2'd3, 16'd65535, 16'd5, 16'd65535, 1'b0, 1'b0);
        // start together with gameover in OVER restarts
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   2'd1, 16'd65535, 16'd0, 16'd65535, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd1, 16'd65535, 16'd0, 16'd65535, 1'b0, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            step1(vq[i].rst, vq[i].st, vq[i].pa, vq[i].go, vq[i].bv, vq[i].ba);
            chk("tbl_state", i, 32'(st1), 32'(vq[i].e_state));
            chk("tbl_score", i, 32'(sc1), 32'(vq[i].e_score));
            chk("tbl_elapsed", i, 32'(el1), 32'(vq[i].e_el));
            chk("tbl_high", i, 32'(hs1), 32'(vq[i].e_hs));
            chk("tbl_tick", i, 32'(tk1), 32'(vq[i].e_tick));
            chk("tbl_newhigh", i, 32'(nh1), 32'(vq[i].e_nh));
        end

        // ---------------- high score across games, reset mid-game ----------------
        step1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("g_reset_high", 0, 32'(hs1), 32'd0);
        step1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 8; k++) step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("g1_score", 0, 32'(sc1), 32'd65405);
        step1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        chk("g1_state", 0, 32'(st1), 32'd3);
        chk("g1_high", 0, 32'(hs1), 32'd65405);
        chk("g1_newhigh", 0, 32'(nh1), 32'd1);
        step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("g1_newhigh_drop", 0, 32'(nh1), 32'd0);
        step1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("g2_reload", 0, 32'(sc1), 32'd65535);
        chk("g2_elapsed0", 0, 32'(el1), 32'd0);
        chk("g2_high_kept", 0, 32'(hs1), 32'd65405);
        for (int k = 0; k < 12; k++) step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("g2_score", 0, 32'(sc1), 32'd65340);
        step1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        chk("g2_state", 0, 32'(st1), 32'd3);
        chk("g2_high", 0, 32'(hs1), 32'd65405);
        chk("g2_newhigh", 0, 32'(nh1), 32'd0);
        step1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 12; k++) step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("g3_score", 0, 32'(sc1), 32'd65340);
        step1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("rst_state", 0, 32'(st1), 32'd0);
        chk("rst_score", 0, 32'(sc1), 32'd0);
        chk("rst_high", 0, 32'(hs1), 32'd0);
        chk("rst_elapsed", 0, 32'(el1), 32'd0);
        chk("rst_tick", 0, 32'(tk1), 32'd0);
        chk("rst_newhigh", 0, 32'(nh1), 32'd0);

        // ---------------- START=100: score reaches zero ----------------
        step2(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step2(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("z_start", 0, 32'(sc2), 32'd100);
        for (int k = 0; k < 4; k++) step2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("z_score35", 0, 32'(sc2), 32'd35);
        chk("z_tick1", 0, 32'(tk2), 32'd1);
        for (int k = 0; k < 4; k++) step2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("z_score0", 0, 32'(sc2), 32'd0);
        chk("z_state_run", 0, 32'(st2), 32'd1);
        chk("z_elapsed", 0, 32'(el2), 32'd2);
        step2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("z_state_over", 0, 32'(st2), 32'd3);
        chk("z_high", 0, 32'(hs2), 32'd0);
        chk("z_newhigh", 0, 32'(nh2), 32'd0);
        step2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("z_newhigh2", 0, 32'(nh2), 32'd0);
        chk("z_hold", 0, 32'(sc2), 32'd0);

        // ---------------- START=100: tick with bonus, signed clamp path ----------------
        step2(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step2(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 4; k++) step2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("b_score35", 0, 32'(sc2), 32'd35);
        for (int k = 0; k < 3; k++) step2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step2(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd60);
        chk("b_score30", 0, 32'(sc2), 32'd30);
        chk("b_tick30", 0, 32'(tk2), 32'd1);
        for (int k = 0; k < 3; k++) step2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step2(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd50);
        chk("b_score15", 0, 32'(sc2), 32'd15);
        chk("b_state", 0, 32'(st2), 32'd1);
        chk("b_elapsed", 0, 32'(el2), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
